// File: rtl/tt_uart_tx_if.sv
// -----------------------------------------------------------------------------
// tt_uart_tx_if
//   Byte handshake between the core logic and the UART transmitter.
//
//   tx_data   8  byte offered by the core
//   tx_valid  1  tx_data is valid this cycle
//   tx_ready  1  transmitter FIFO can take a byte this cycle
//
//   master : core side (drives data/valid, sees ready)
//   slave  : transmitter side (sees data/valid, drives ready)
// -----------------------------------------------------------------------------
interface tt_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/tt_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_uart_tx
//   UART transmitter for the Tiny Tapeout user core. Bytes arrive over a
//   valid/ready handshake, queue in a small circular FIFO and leave LSB first
//   on a single serial pin, framed as 8N1 (or 8E1, see below). Frames are sent
//   back to back with no idle gap while the FIFO holds data.
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//     FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
//   Ports
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     ena_i         design enable; low freezes the whole block
//     in_if         byte handshake (slave side of tt_uart_tx_if)
//     tx_o          serial line, registered, idle high
//     busy_o        frame in progress or FIFO non-empty
//     fifo_count_o  bytes currently held in the FIFO
//
//   Build option
//     UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                        last data bit and the stop bit (8E1 frame).
// -----------------------------------------------------------------------------
module tt_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena_i,
  tt_uart_tx_if.slave                   in_if,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic       full, empty, push, pop, baud_done, start_frame;
  logic [7:0] head;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign baud_done = (baud_q == '0);

  // Ready looks only at the registered count, so a pop in the same cycle
  // never lets a byte in early.
  assign in_if.tx_ready = ena_i && !full;
  assign push           = ena_i && in_if.tx_valid && !full;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (ena_i) begin
      case (state_q)
        IDLE: start_frame = !empty;
        START: begin
          if (baud_done) begin
            state_d   = DATA;
            bit_idx_d = '0;
            baud_d    = BAUD_LOAD;
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_d = BAUD_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              shift_d   = shift_q >> 1;
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state_d = STOP;
            baud_d  = BAUD_LOAD;
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            // Chain straight into the next start bit when data is waiting.
            start_frame = !empty;
            if (empty) state_d = IDLE;
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      state_d = START;
      baud_d  = BAUD_LOAD;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // The line level is decoded from the next state so tx_o comes straight
  // from a flop and changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.tx_data;
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE) || !empty;
  assign fifo_count_o = count_q;

endmodule
